ir_packet_scheduler: RTL and testbench

//  Sequences the IR packet transmitter. Owns the packet-rate period counter and round-robin

---
 rtl/ir_packet_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ir_packet_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: packet-rate tick, round-robin source arbitration and START/BUSY handshake.
// Optional macro IR_KEEPALIVE_EN: ticks with no valid source send a zero-command keepalive packet.
module ir_packet_scheduler #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned CMD_W         = 4,
  parameter int unsigned PERIOD_CYCLES = 10_000_000,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic [NUM_SRC-1:0]       SRC_VALID,
  input  logic [NUM_SRC*CMD_W-1:0] SRC_CMD,
  input  logic                     TX_BUSY,
  output logic                     TX_START,
  output logic [CMD_W-1:0]         TX_CMD,
  output logic [NUM_SRC-1:0]       GRANT,
  output logic                     OVERRUN,
  output logic                     TIMEOUT_ERR
);

  localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT);
  localparam int unsigned PTR_W = $clog2(NUM_SRC);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]         state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic               tx_start_d, overrun_d, timeout_d;
  logic [CMD_W-1:0]   tx_cmd_d;
  logic [NUM_SRC-1:0] grant_d;
  logic               tick_c;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [CMD_W-1:0]   pick_cmd;
  logic [NUM_SRC-1:0] pick_grant;
  int unsigned        cand;

  assign tick_c = (cnt == CNT_W'(PERIOD_CYCLES - 1));

  // Round-robin search: first valid source starting one past the last grant.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr;
    pick_cmd   = '0;
    pick_grant = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(ptr) + k) % NUM_SRC;
      if (!pick_valid && SRC_VALID[PTR_W'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = PTR_W'(cand);
        pick_cmd   = CMD_W'(SRC_CMD >> (cand * CMD_W));
        pick_grant = NUM_SRC'(32'd1 << cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = tick_c ? '0 : cnt + CNT_W'(1);
    tmr_d      = tmr;
    ptr_d      = ptr;
    tx_start_d = TX_START;
    tx_cmd_d   = TX_CMD;
    grant_d    = GRANT;
    overrun_d  = OVERRUN;
    timeout_d  = TIMEOUT_ERR;

    if (!ENABLE) begin
      state_d    = IDLE;
      cnt_d      = '0;
      tmr_d      = '0;
      tx_start_d = 1'b0;
      grant_d    = '0;
      overrun_d  = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      // A tick outside IDLE is a skipped slot, even if the packet ends this cycle.
      if (tick_c && (state != IDLE)) begin
        overrun_d = 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick_c) begin
            if (pick_valid) begin
              state_d    = START;
              tmr_d      = '0;
              ptr_d      = pick_idx;
              tx_start_d = 1'b1;
              tx_cmd_d   = pick_cmd;
              grant_d    = pick_grant;
            end
`ifdef IR_KEEPALIVE_EN
            else begin
              state_d    = START;
              tmr_d      = '0;
              tx_start_d = 1'b1;
              tx_cmd_d   = '0;
              grant_d    = '0;
            end
`endif
          end
        end
        START: begin
          if (TX_BUSY) begin
            state_d    = WAIT;
            tx_start_d = 1'b0;
          end else if (tmr == TMR_W'(ACK_TIMEOUT - 1)) begin
            state_d    = IDLE;
            tx_start_d = 1'b0;
            grant_d    = '0;
            timeout_d  = 1'b1;
          end else begin
            tmr_d = tmr + TMR_W'(1);
          end
        end
        WAIT: begin
          if (!TX_BUSY) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          tx_start_d = 1'b0;
          grant_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      ptr         <= PTR_W'(NUM_SRC - 1);
      TX_START    <= 1'b0;
      TX_CMD      <= '0;
      GRANT       <= '0;
      OVERRUN     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      tmr         <= tmr_d;
      ptr         <= ptr_d;
      TX_START    <= tx_start_d;
      TX_CMD      <= tx_cmd_d;
      GRANT       <= grant_d;
      OVERRUN     <= overrun_d;
      TIMEOUT_ERR <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Bench for ir_packet_scheduler: directed scenarios plus random traffic against a slot-level
// reference model, with a simple transmitter that holds busy for a programmable length.
module tb_ir_packet_scheduler;

  localparam int NSRC   = 2;
  localparam int CMD_W  = 4;
  localparam int PERIOD = 20;
  localparam int ACK    = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SEND = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] src_valid;
  logic [7:0] src_cmd;
  logic       tx_busy;
  logic       tx_start;
  logic [3:0] tx_cmd;
  logic [1:0] grant;
  logic       overrun;
  logic       timeout_err;

  always #5 clk = ~clk;

  ir_packet_scheduler #(
    .NUM_SRC(NSRC), .CMD_W(CMD_W), .PERIOD_CYCLES(PERIOD), .ACK_TIMEOUT(ACK)
  ) dut (
    .CLK(clk), .RESET(rst_n), .ENABLE(enable),
    .SRC_VALID(src_valid), .SRC_CMD(src_cmd), .TX_BUSY(tx_busy),
    .TX_START(tx_start), .TX_CMD(tx_cmd), .GRANT(grant),
    .OVERRUN(overrun), .TIMEOUT_ERR(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: packet phase, slot position and expected outputs.
  int         m_t, m_phase, m_age, m_ptr;
  logic       e_start, e_ovr, e_to;
  logic [3:0] e_cmd;
  logic [1:0] e_grant;

  // Transmitter environment and observation log.
  int  busy_left = 0;
  int  busy_len  = 5;
  bit  tx_dead   = 1'b0;
  int  cyc       = 0;
  bit  prev_start = 1'b0;
  int  rise_cyc[$];
  int  fall_cyc[$];
  logic [3:0] rise_cmd[$];
  logic [1:0] rise_grant[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_phase = PH_IDLE; m_age = 0; m_ptr = NSRC - 1;
    e_start = 0; e_ovr = 0; e_to = 0; e_cmd = '0; e_grant = '0;
  endtask

  task automatic model_step();
    bit         tick;
    int         win;
    logic [1:0] v;
    logic [7:0] c;
    if (!enable) begin
      m_t = 0; m_phase = PH_IDLE; m_age = 0;
      e_start = 0; e_grant = '0; e_ovr = 0; e_to = 0;
      return;
    end
    tick = (m_t == PERIOD - 1);
    m_t  = (m_t + 1) % PERIOD;
    if (tick && m_phase != PH_IDLE) e_ovr = 1;
    case (m_phase)
      PH_IDLE: if (tick) begin
        win = -1;
        for (int k = 1; k <= NSRC; k++) begin
          v = src_valid >> ((m_ptr + k) % NSRC);
          if (win < 0 && v[0]) win = (m_ptr + k) % NSRC;
        end
        if (win >= 0) begin
          c = src_cmd >> (win * CMD_W);
          e_cmd = c[3:0]; e_grant = 2'(1 << win); m_ptr = win;
          m_phase = PH_REQ; m_age = 0; e_start = 1;
        end
`ifdef IR_KEEPALIVE_EN
        else begin
          e_cmd = '0; e_grant = '0; m_phase = PH_REQ; m_age = 0; e_start = 1;
        end
`endif
      end
      PH_REQ: begin
        if (tx_busy) begin
          m_phase = PH_SEND; e_start = 0;
        end else begin
          m_age++;
          if (m_age == ACK) begin
            e_to = 1; m_phase = PH_IDLE; e_start = 0; e_grant = '0;
          end
        end
      end
      PH_SEND: if (!tx_busy) begin
        m_phase = PH_IDLE; e_grant = '0;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic clear_log();
    rise_cyc.delete(); fall_cyc.delete(); rise_cmd.delete(); rise_grant.delete();
  endtask

  // One clock: drive busy, advance the model, check just after the edge, update transmitter.
  task automatic step();
    tx_busy = (busy_left > 0);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("tx_start", 32'(tx_start), 32'(e_start));
    check("tx_cmd", 32'(tx_cmd), 32'(e_cmd));
    check("grant", 32'(grant), 32'(e_grant));
    check("overrun", 32'(overrun), 32'(e_ovr));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
    if (tx_start && !prev_start) begin
      rise_cyc.push_back(cyc); rise_cmd.push_back(tx_cmd); rise_grant.push_back(grant);
    end
    if (!tx_start && prev_start) fall_cyc.push_back(cyc);
    prev_start = tx_start;
    if (busy_left > 0) busy_left--;
    else if (tx_start && !tx_dead) busy_left = busy_len;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_cmd", 32'(tx_cmd), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; prev_start = 1'b0; clear_log();
  endtask

  logic [3:0] rr_cmd_exp [4];
  logic [1:0] rr_grant_exp [4];
  int         tx_mode;
  int         base;

  initial begin
    rr_cmd_exp   = '{4'h1, 4'h8, 4'h1, 4'h8};
    rr_grant_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0; enable = 1'b1; src_valid = '0; src_cmd = '0; tx_busy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_tx_start", 32'(tx_start), 0);
    check("por_grant", 32'(grant), 0);
    check("por_tx_cmd", 32'(tx_cmd), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with both sources valid.
    src_valid = 2'b11; src_cmd = {4'h8, 4'h1}; busy_len = 5;
    run(85);
    check("rr_first_tick_cyc", 32'(rise_cyc.size() > 0 ? rise_cyc[0] : -1), 20);
    check("rr_packets", 32'(rise_cmd.size()), 4);
    for (int i = 0; i < 4 && i < rise_cmd.size(); i++) begin
      check("rr_cmd", 32'(rise_cmd[i]), 32'(rr_cmd_exp[i]));
      check("rr_grant", 32'(rise_grant[i]), 32'(rr_grant_exp[i]));
    end
    check("hs_start_width", 32'(fall_cyc.size() > 0 ? fall_cyc[0] - rise_cyc[0] : -1), 1);

    // Mid-count asynchronous reset while a packet is in flight.
    run(7);
    async_reset();
    busy_left = 0;

    // Overrun: long packet makes the next slot skip.
    src_valid = 2'b01; busy_len = 30;
    run(70);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_rises", 32'(rise_cyc.size()), 2);
    check("ovr_skip_cyc", 32'(rise_cyc.size() > 1 ? rise_cyc[1] : -1), 60);
    check("ovr_grant_same", 32'(rise_grant.size() > 1 ? rise_grant[1] : 2'b00), 32'(2'b01));
    enable = 1'b0;
    step();
    check("ovr_cleared", 32'(overrun), 0);
    enable = 1'b1;

    // Timeout: transmitter never answers.
    busy_left = 0; tx_dead = 1'b1; src_valid = 2'b10; clear_log(); base = cyc;
    run(45);
    check("to_start_width", 32'(fall_cyc.size() > 0 && rise_cyc.size() > 0 ?
                              fall_cyc[0] - rise_cyc[0] : -1), 8);
    check("to_flag", 32'(timeout_err), 1);
    check("to_retry_cyc", 32'(rise_cyc.size() > 1 ? rise_cyc[1] - base : -1), 40);

    // No valid source.
    enable = 1'b0; step(); enable = 1'b1;
    tx_dead = 1'b0; busy_len = 5; src_valid = 2'b00; clear_log();
    run(45);
`ifdef IR_KEEPALIVE_EN
    check("ka_packets", 32'(rise_cyc.size()), 2);
`else
    check("ka_packets", 32'(rise_cyc.size()), 0);
`endif

    // Random traffic against the model.
    tx_mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) tx_mode = $urandom_range(0, 2);
      enable    = ($urandom_range(0, 149) != 0);
      src_valid = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) src_cmd = 8'($urandom);
      busy_len  = $urandom_range(1, 30);
      tx_dead   = (tx_mode == 2) || (tx_mode == 1 && $urandom_range(0, 1) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
